// File: rtl/interrupt_coalesce_ctrl.sv
// interrupt_coalesce_ctrl
//   Collects NUM_SRC interrupt sources into sticky pending flags and raises
//   a single aggregated irq. irq fires once enough flags are pending or a
//   coalescing timer expires. It then stays high until every flag is cleared.
//
// Ports
//   CLK      single clock, rising edge
//   RST      asynchronous active-high reset
//   src      raw interrupt sources (synchronous to CLK)
//   mode     per-source detect mode, 2 bits each: 00 level, 01 rising,
//            10 falling, 11 both edges
//   enable   per-source enable mask (disabled flags clear on the next edge)
//   clear    write-1-to-clear pulse per flag (wins over set and events)
//   set      software-set pulse per flag
//   thresh   pending-count threshold for irq (0 behaves as 1)
//   timeout  coalescing timeout in cycles, 0 disables the timer
//   flags    registered pending flags
//   irq      registered aggregated interrupt request
//   irq_id   index of the lowest-numbered set flag (0 when none)
module interrupt_coalesce_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int TMR_W   = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_SRC-1:0]           src,
  input  logic [2*NUM_SRC-1:0]         mode,
  input  logic [NUM_SRC-1:0]           enable,
  input  logic [NUM_SRC-1:0]           clear,
  input  logic [NUM_SRC-1:0]           set,
  input  logic [$clog2(NUM_SRC+1)-1:0] thresh,
  input  logic [TMR_W-1:0]             timeout,
  output logic [NUM_SRC-1:0]           flags,
  output logic                         irq,
  output logic [$clog2(NUM_SRC)-1:0]   irq_id
);

  localparam int CNT_W = $clog2(NUM_SRC+1);
  localparam int ID_W  = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_e;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] ev;
  logic [NUM_SRC-1:0] flag_n;
  logic [CNT_W-1:0]   pend_cnt;
  logic [CNT_W-1:0]   eff_thresh;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   tmr_n;
  logic [TMR_W:0]     tmr_inc;
  logic               tmo_hit;
  logic               irq_n;
  logic               id_found;

  // Event detection against the previous-cycle sample.
  always_comb begin
    ev = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      case (mode_e'(mode[2*i +: 2]))
        MODE_LEVEL: ev[i] = src[i];
        MODE_RISE:  ev[i] = src[i] & ~src_q[i];
        MODE_FALL:  ev[i] = ~src[i] & src_q[i];
        MODE_BOTH:  ev[i] = src[i] ^ src_q[i];
      endcase
    end
  end

  // Clear dominates; enable masks the whole result.
  assign flag_n = enable & ~clear & (flags | ev | set);

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pend_cnt = pend_cnt + CNT_W'(flag_n[i]);
    end
  end

  assign eff_thresh = (thresh == '0) ? CNT_W'(1) : thresh;

  // One extra bit so a saturated timer still compares as expired.
  assign tmr_inc = {1'b0, tmr} + (TMR_W+1)'(1);
  assign tmo_hit = (timeout != '0) && (tmr_inc >= {1'b0, timeout});

  always_comb begin
    irq_n = 1'b0;
    if (flag_n == '0) begin
      irq_n = 1'b0;
    end else if (irq) begin
      irq_n = 1'b1;
    end else if (pend_cnt >= eff_thresh) begin
      irq_n = 1'b1;
    end else if (tmo_hit) begin
      irq_n = 1'b1;
    end
  end

  always_comb begin
    tmr_n = tmr;
    if ((flag_n == '0) || irq_n) begin
      tmr_n = '0;
    end else if (tmr != '1) begin
      tmr_n = tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      src_q <= '0;
      flags <= '0;
      irq   <= 1'b0;
      tmr   <= '0;
    end else begin
      src_q <= src;
      flags <= flag_n;
      irq   <= irq_n;
      tmr   <= tmr_n;
    end
  end

  // Lowest index wins.
  always_comb begin
    irq_id   = '0;
    id_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (flags[i] && !id_found) begin
        irq_id   = ID_W'(i);
        id_found = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_coalesce_ctrl.sv
module tb_interrupt_coalesce_ctrl;

  localparam int NS = 8;
  localparam int TW = 8;
  localparam int TMR_MAX = (1 << TW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [NS-1:0] t_src = '0;
  logic [2*NS-1:0] t_mode = '0;
  logic [NS-1:0] t_en = '0;
  logic [NS-1:0] t_clr = '0;
  logic [NS-1:0] t_set = '0;
  logic [3:0]    t_th = '0;
  logic [TW-1:0] t_to = '0;
  logic [NS-1:0] flags;
  logic          irq;
  logic [2:0]    irq_id;

  interrupt_coalesce_ctrl #(.NUM_SRC(NS), .TMR_W(TW)) dut (
    .CLK(CLK), .RST(RST), .src(t_src), .mode(t_mode), .enable(t_en),
    .clear(t_clr), .set(t_set), .thresh(t_th), .timeout(t_to),
    .flags(flags), .irq(irq), .irq_id(irq_id)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NS-1:0] f;
    logic          i;
    logic [2:0]    id;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state.
  bit [NS-1:0] m_flags, m_prev;
  bit          m_irq;
  int          m_tmr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Apply one cycle of inputs at a negedge, predict the post-edge outputs,
  // queue them, and return at the following negedge.
  task automatic step(input logic [NS-1:0] s, input logic [NS-1:0] c, input logic [NS-1:0] st);
    bit [NS-1:0] nf;
    bit e;
    int cnt, eff;
    exp_t x;
    t_src = s; t_clr = c; t_set = st;
    nf = '0;
    for (int i = 0; i < NS; i++) begin
      case (t_mode[2*i +: 2])
        2'd0: e = s[i];
        2'd1: e = s[i] && !m_prev[i];
        2'd2: e = !s[i] && m_prev[i];
        default: e = (s[i] != m_prev[i]);
      endcase
      nf[i] = t_en[i] && !c[i] && (m_flags[i] || e || st[i]);
    end
    cnt = $countones(nf);
    eff = (t_th == 0) ? 1 : int'(t_th);
    if (nf == 0) begin
      m_irq = 0; m_tmr = 0;
    end else if (m_irq || cnt >= eff || (t_to != 0 && m_tmr + 1 >= int'(t_to))) begin
      m_irq = 1; m_tmr = 0;
    end else begin
      m_irq = 0;
      m_tmr = (m_tmr >= TMR_MAX) ? TMR_MAX : m_tmr + 1;
    end
    m_flags = nf;
    m_prev  = s;
    x.f = nf; x.i = m_irq; x.id = 3'(lowest(nf));
    sbq.push_back(x);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    chk("rst_flags", 32'(flags), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(irq_id), 0);
    m_flags = '0; m_prev = '0; m_irq = 0; m_tmr = 0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic cfg(input logic [2*NS-1:0] md, input logic [NS-1:0] en,
                     input logic [3:0] th, input logic [TW-1:0] to);
    t_mode = md; t_en = en; t_th = th; t_to = to;
  endtask

  // Monitor: every clock edge with reset released produces one output word.
  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST && sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("sb_flags", 32'(flags), 32'(x.f));
        chk("sb_irq", 32'(irq), 32'(x.i));
        chk("sb_id", 32'(irq_id), 32'(x.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();

    // Rising edge on src[3], held high; clear does not re-flag.
    cfg(16'h5555, 8'hFF, 4'd1, 8'd0);
    step(8'h00, 8'h00, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    chk("rise_flags", 32'(flags), 32'h08);
    chk("rise_irq", 32'(irq), 1);
    chk("rise_id", 32'(irq_id), 3);
    step(8'h08, 8'h08, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    chk("rise_noreflag", 32'(flags), 0);

    // Level source held high with a one-cycle clear.
    cfg(16'h0000, 8'hFF, 4'd1, 8'd0);
    step(8'h01, 8'h00, 8'h00);
    chk("lvl_set", 32'(flags), 32'h01);
    step(8'h01, 8'h01, 8'h00);
    chk("lvl_clr", 32'(flags), 0);
    step(8'h01, 8'h00, 8'h00);
    chk("lvl_reassert", 32'(flags), 32'h01);

    // Threshold of three pending flags.
    step(8'h00, 8'hFF, 8'h00);
    cfg(16'h0000, 8'hFF, 4'd3, 8'd0);
    step(8'h00, 8'h00, 8'h01);
    chk("th_irq1", 32'(irq), 0);
    step(8'h00, 8'h00, 8'h04);
    chk("th_irq2", 32'(irq), 0);
    step(8'h00, 8'h00, 8'h80);
    chk("th_flags", 32'(flags), 32'h85);
    chk("th_irq3", 32'(irq), 1);
    chk("th_id", 32'(irq_id), 0);

    // Timeout of five with a single pending flag.
    step(8'h00, 8'hFF, 8'h00);
    cfg(16'h0000, 8'hFF, 4'd4, 8'd5);
    step(8'h00, 8'h00, 8'h04);
    chk("tmo_wait0", 32'(irq), 0);
    for (int k = 1; k <= 3; k++) begin
      step(8'h00, 8'h00, 8'h00);
      chk("tmo_wait", 32'(irq), 0);
    end
    step(8'h00, 8'h00, 8'h00);
    chk("tmo_fire", 32'(irq), 1);
    step(8'h00, 8'hFF, 8'h00);
    chk("tmo_clr_irq", 32'(irq), 0);

    // Clear beats set; edge while disabled is dropped.
    cfg(16'hAAAA, 8'hFF, 4'd1, 8'd0);
    step(8'h00, 8'h20, 8'h20);
    chk("clr_vs_set", 32'(flags[5]), 0);
    step(8'h20, 8'h00, 8'h00);
    t_en = 8'hDF;
    step(8'h00, 8'h00, 8'h00);
    chk("dis_drop", 32'(flags[5]), 0);
    t_en = 8'hFF;
    step(8'h00, 8'h00, 8'h00);
    chk("dis_lost", 32'(flags[5]), 0);

    // Asynchronous reset mid-operation; rising edge seen right after release.
    cfg(16'h5555, 8'hFF, 4'd1, 8'd0);
    step(8'h00, 8'h00, 8'hFF);
    chk("pre_rst_flags", 32'(flags), 32'hFF);
    chk("pre_rst_irq", 32'(irq), 1);
    t_src = 8'h02;
    do_reset();
    step(8'h02, 8'h00, 8'h00);
    chk("post_rst_edge", 32'(flags), 32'h02);

    // Randomized traffic with block-wise random configuration.
    for (int blk = 0; blk < 30; blk++) begin
      cfg(16'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
          4'($urandom_range(0, 10)),
          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20)));
      if (blk % 10 == 9) do_reset();
      for (int n = 0; n < 50; n++) begin
        step(8'($urandom),
             ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00,
             ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      end
    end

    @(negedge CLK);
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
